// File: rtl/exe_stage_if.sv
// ID/EXE inputs, forwarding operands and EXE/MEM register outputs of the execute stage.
// The master side drives the instruction slot; the slave side is the execute stage.
interface exe_stage_if;
  logic        valid_in;
  logic [3:0]  exe_cmd;
  logic        s_en;
  logic        imm;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [3:0]  dest_in;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic [31:0] val2;
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] mem_fwd_val;
  logic [31:0] wb_fwd_val;
  logic        freeze;
  logic        flush;

  logic [31:0] alu_res_out;
  logic [31:0] st_val_out;
  logic [3:0]  dest_out;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic        mem_w_en_out;
  logic        valid_out;
  logic [3:0]  status_out;

  modport master (
    output valid_in, exe_cmd, s_en, imm, wb_en_in, mem_r_en_in, mem_w_en_in,
           dest_in, val_rn, val_rm, val2, sel_src1, sel_src2,
           mem_fwd_val, wb_fwd_val, freeze, flush,
    input  alu_res_out, st_val_out, dest_out, wb_en_out, mem_r_en_out,
           mem_w_en_out, valid_out, status_out
  );

  modport slave (
    input  valid_in, exe_cmd, s_en, imm, wb_en_in, mem_r_en_in, mem_w_en_in,
           dest_in, val_rn, val_rm, val2, sel_src1, sel_src2,
           mem_fwd_val, wb_fwd_val, freeze, flush,
    output alu_res_out, st_val_out, dest_out, wb_en_out, mem_r_en_out,
           mem_w_en_out, valid_out, status_out
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU with {N,Z,C,V} status register,
// and the EXE/MEM pipeline register with flush/freeze control.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001,
    CMD_CMP = 4'b1100,
    CMD_TST = 4'b1110
  } alu_cmd_e;

  alu_cmd_e    cmd;
  logic [31:0] op1;
  logic [31:0] fwd_rm;
  logic [31:0] op2;
  logic [32:0] sum33;
  logic [32:0] diff33;
  logic        c_in;
  logic        b_in;

  logic [31:0] alu_res;
  logic        n_new;
  logic        z_new;
  logic        c_new;
  logic        v_new;
  logic        cmd_defined;
  logic        no_writeback;

  logic [31:0] alu_res_q;
  logic [31:0] st_val_q;
  logic [3:0]  dest_q;
  logic        wb_en_q;
  logic        mem_r_en_q;
  logic        mem_w_en_q;
  logic        valid_q;
  logic [3:0]  status_q;

  function automatic logic [31:0] fwd_mux(
    input logic [1:0]  sel,
    input logic [31:0] reg_val,
    input logic [31:0] mem_val,
    input logic [31:0] wb_val
  );
    case (sel)
      2'b01:   fwd_mux = mem_val;
      2'b10:   fwd_mux = wb_val;
      default: fwd_mux = reg_val;
    endcase
  endfunction

  assign cmd    = alu_cmd_e'(bus.exe_cmd);
  assign op1    = fwd_mux(bus.sel_src1, bus.val_rn, bus.mem_fwd_val, bus.wb_fwd_val);
  assign fwd_rm = fwd_mux(bus.sel_src2, bus.val_rm, bus.mem_fwd_val, bus.wb_fwd_val);
  assign op2    = bus.imm ? bus.val2 : fwd_rm;

  // Carry-in for ADC and borrow-in for SBC come from the registered C flag.
  assign c_in   = (cmd == CMD_ADC) ? status_q[1] : 1'b0;
  assign b_in   = (cmd == CMD_SBC) ? ~status_q[1] : 1'b0;
  assign sum33  = {1'b0, op1} + {1'b0, op2} + {32'd0, c_in};
  assign diff33 = {1'b0, op1} - {1'b0, op2} - {32'd0, b_in};

  always_comb begin
    alu_res     = '0;
    c_new       = status_q[1];
    v_new       = status_q[0];
    cmd_defined = 1'b1;
    case (cmd)
      CMD_MOV: alu_res = op2;
      CMD_MVN: alu_res = ~op2;
      CMD_ADD, CMD_ADC: begin
        alu_res = sum33[31:0];
        c_new   = sum33[32];
        v_new   = (op1[31] == op2[31]) && (sum33[31] != op1[31]);
      end
      CMD_SUB, CMD_SBC, CMD_CMP: begin
        alu_res = diff33[31:0];
        c_new   = ~diff33[32];
        v_new   = (op1[31] != op2[31]) && (diff33[31] != op1[31]);
      end
      CMD_AND, CMD_TST: alu_res = op1 & op2;
      CMD_ORR:          alu_res = op1 | op2;
      CMD_EOR:          alu_res = op1 ^ op2;
      default:          cmd_defined = 1'b0;
    endcase
  end

  assign n_new        = alu_res[31];
  assign z_new        = (alu_res == 32'd0);
  assign no_writeback = (cmd == CMD_CMP) || (cmd == CMD_TST);

  // Flush only kills the control bits; data fields keep their last contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      valid_q    <= 1'b0;
      status_q   <= '0;
    end else if (bus.flush) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (!bus.freeze) begin
      alu_res_q  <= alu_res;
      st_val_q   <= fwd_rm;
      dest_q     <= bus.dest_in;
      wb_en_q    <= bus.valid_in & bus.wb_en_in & ~no_writeback;
      mem_r_en_q <= bus.valid_in & bus.mem_r_en_in;
      mem_w_en_q <= bus.valid_in & bus.mem_w_en_in;
      valid_q    <= bus.valid_in;
      if (bus.valid_in && bus.s_en && cmd_defined) begin
        status_q <= {n_new, z_new, c_new, v_new};
      end
    end
  end

  assign bus.alu_res_out  = alu_res_q;
  assign bus.st_val_out   = st_val_q;
  assign bus.dest_out     = dest_q;
  assign bus.wb_en_out    = wb_en_q;
  assign bus.mem_r_en_out = mem_r_en_q;
  assign bus.mem_w_en_out = mem_w_en_q;
  assign bus.valid_out    = valid_q;
  assign bus.status_out   = status_q;

endmodule
